// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, FSM state
// codes, ALU function codes and the decoded-instruction bundle.
package mcpu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_RSUB = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ANDN = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_XNOR = 3'b111;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_ALU_R,
    CL_ALU_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_HALT
  } opClass_e;

  typedef struct packed {
    opClass_e   cls;
    logic [2:0] aluOp;
    logic       aluSrcB;
    logic       extSel;
    logic       regDst;
  } decode_t;

endpackage

// File: rtl/mcpu_opdecode.sv
// Combinational opcode decoder: instruction class plus the static datapath
// controls that depend only on the opcode.
module mcpu_opdecode
  import mcpu_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opCode,
  output decode_t        dec
);

  // Opcode table; anything not listed is treated as a NOP.
  always_comb begin
    dec = '{cls: CL_NOP, aluOp: ALU_ADD, aluSrcB: 1'b0, extSel: 1'b0, regDst: 1'b0};
    case (opCode)
      OP_ADD:  dec = '{cls: CL_ALU_R,  aluOp: ALU_ADD, aluSrcB: 1'b0, extSel: 1'b0, regDst: 1'b1};
      OP_SUB:  dec = '{cls: CL_ALU_R,  aluOp: ALU_SUB, aluSrcB: 1'b0, extSel: 1'b0, regDst: 1'b1};
      OP_OR:   dec = '{cls: CL_ALU_R,  aluOp: ALU_OR,  aluSrcB: 1'b0, extSel: 1'b0, regDst: 1'b1};
      OP_AND:  dec = '{cls: CL_ALU_R,  aluOp: ALU_AND, aluSrcB: 1'b0, extSel: 1'b0, regDst: 1'b1};
      OP_ADDI: dec = '{cls: CL_ALU_I,  aluOp: ALU_ADD, aluSrcB: 1'b1, extSel: 1'b1, regDst: 1'b0};
      OP_ORI:  dec = '{cls: CL_ALU_I,  aluOp: ALU_OR,  aluSrcB: 1'b1, extSel: 1'b0, regDst: 1'b0};
      OP_SW:   dec = '{cls: CL_STORE,  aluOp: ALU_ADD, aluSrcB: 1'b1, extSel: 1'b1, regDst: 1'b0};
      OP_LW:   dec = '{cls: CL_LOAD,   aluOp: ALU_ADD, aluSrcB: 1'b1, extSel: 1'b1, regDst: 1'b0};
      OP_BEQ:  dec = '{cls: CL_BRANCH, aluOp: ALU_SUB, aluSrcB: 1'b0, extSel: 1'b1, regDst: 1'b0};
      OP_HALT: dec = '{cls: CL_HALT,   aluOp: ALU_ADD, aluSrcB: 1'b0, extSel: 1'b0, regDst: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Five-phase multicycle CPU controller (IF, ID, EXE, MEM, WB).
//
//   state  | meaning
//   S_IF   | fetch: read instruction memory, load IR
//   S_ID   | decode; NOP retires here, HALT parks
//   S_EXE  | ALU operation; BEQ resolves on zero and retires
//   S_MEM  | data memory access; SW retires
//   S_WB   | register write-back; ALU ops and LW retire
//   S_HALT | parked until Reset
//
// Outputs decode the state register (plus the stable IR opcode), so they
// follow the state with no extra cycle of latency. PCSrc in BEQ's EXE also
// follows zero combinationally. Everything is forced low while Reset is high
// so an aborted store or write-back drops in the same cycle.
module multicycle_control_unit
  import mcpu_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 3
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] opCode,
  input  logic           zero,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           ExtSel,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           RegDst,
  output logic           RegWre,
  output logic           mRD,
  output logic           mWR,
  output logic           DBDataSrc,
  output logic [1:0]     PCSrc,
  output logic [STW-1:0] state
);

  decode_t dec;

  mcpu_opdecode #(.OPW(OPW)) uDecode (
    .opCode (opCode),
    .dec    (dec)
  );

  // State register and transition table; unused codes recover to fetch.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_IF;
    end else begin
      case (state)
        S_IF:  state <= S_ID;
        S_ID: begin
          if (dec.cls == CL_HALT)     state <= S_HALT;
          else if (dec.cls == CL_NOP) state <= S_IF;
          else                        state <= S_EXE;
        end
        S_EXE: begin
          if (dec.cls == CL_ALU_R || dec.cls == CL_ALU_I)      state <= S_WB;
          else if (dec.cls == CL_LOAD || dec.cls == CL_STORE) state <= S_MEM;
          else                                                state <= S_IF;
        end
        S_MEM:  state <= (dec.cls == CL_LOAD) ? S_WB : S_IF;
        S_WB:   state <= S_IF;
        S_HALT: state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // Output decode from the current state; ALU controls hold from EXE to WB.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    RegDst    = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    if (!Reset) begin
      if (state == S_EXE || state == S_MEM || state == S_WB) begin
        ALUOp   = dec.aluOp;
        ALUSrcB = dec.aluSrcB;
        ExtSel  = dec.extSel;
      end
      case (state)
        S_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
        end
        S_ID:  PCWre = (dec.cls == CL_NOP);
        S_EXE: begin
          if (dec.cls == CL_BRANCH) begin
            PCWre = 1'b1;
            PCSrc = zero ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          mRD   = (dec.cls == CL_LOAD);
          mWR   = (dec.cls == CL_STORE);
          PCWre = (dec.cls == CL_STORE);
        end
        S_WB: begin
          RegWre    = 1'b1;
          PCWre     = 1'b1;
          RegDst    = dec.regDst;
          DBDataSrc = (dec.cls == CL_LOAD);
        end
        default: ;
      endcase
    end
  end

endmodule
